spi_arbiter: RTL and testbench

Round-robin controller that shares one SPI master engine between NREQ requesters, each addressing its own slave. It accepts word-transfer requests, sequences the master's start/working handshake, and steers the master's single chip-select onto the granted slave's select line. It returns the received word with a one-cycle acknowledge, then enforces a programmable idle gap before the next transfer. It sits between the system logic and the SPI master, sharing that engine's clock and reset.

---
 rtl/spi_arbiter.sv | 125 ++++++++++++
 tb/tb_spi_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master engine between NREQ requesters in
// round-robin order, steering the master's chip-select onto the granted
// slave and returning the received word with a one-cycle acknowledge.
module spi_arbiter #(
  parameter int NREQ    = 4,
  parameter int BITS    = 16,
  parameter int IDLEGAP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BITS-1:0] reqData,
  output logic [NREQ-1:0]      ack,
  output logic [BITS-1:0]      rdData,
  output logic [NREQ-1:0]      grant,
  output logic                 spiStart,
  output logic [BITS-1:0]      spiDataOut,
  input  logic                 spiWorking,
  input  logic [BITS-1:0]      spiDataIn,
  input  logic                 spiCs,
  output logic [NREQ-1:0]      csN
);

  localparam int PW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, START, BUSY, DONE, GAP} state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] arb_idx;
  logic          arb_found;
  logic          arb_go;
  logic [PW:0]   cand;
  logic [7:0]    gap_cnt;

  // Round-robin search: first requesting index at or after ptr, wrapping
  // with an explicit compare so non-power-of-2 NREQ works.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand > (PW+1)'(NREQ-1)) cand = cand - (PW+1)'(NREQ);
      if (!arb_found && req[cand[PW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[PW-1:0];
      end
    end
  end

  assign arb_go = arb_found && !spiWorking;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic for the start/working handshake and the idle gap.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_go) state_next = START;
      START:   if (spiWorking) state_next = BUSY;
      BUSY:    if (!spiWorking) state_next = DONE;
      DONE:    state_next = (IDLEGAP == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt <= 8'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: grant, transmit word, captured receive word,
  // round-robin pointer and gap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      win_idx    <= '0;
      grant      <= '0;
      spiDataOut <= '0;
      rdData     <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_go) begin
            win_idx    <= arb_idx;
            grant      <= ONE_HOT0 << arb_idx;
            spiDataOut <= reqData[arb_idx*BITS +: BITS];
          end
        end
        BUSY: begin
          if (!spiWorking) rdData <= spiDataIn;
        end
        DONE: begin
          grant   <= '0;
          gap_cnt <= 8'(IDLEGAP);
          ptr     <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
        end
        GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Moore-style outputs: start strobe until the master reacts, ack in DONE.
  always_comb begin
    spiStart = 1'b0;
    ack      = '0;
    case (state)
      START:   spiStart = !spiWorking;
      DONE:    ack      = ONE_HOT0 << win_idx;
      default: ;
    endcase
  end

  // Only the granted slave sees the master's chip-select.
  assign csN = ~grant | {NREQ{spiCs}};

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed tests for spi_arbiter with a behavioural
// loopback SPI master. Main DUT uses IDLEGAP=5, a second uses IDLEGAP=0.
`timescale 1ns/1ps
module tb_spi_arbiter;

  localparam int NREQ = 4;
  localparam int BITS = 16;
  localparam int MLEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*BITS-1:0] req_data = '0;
  logic [NREQ-1:0]      hold_mask = '0;

  logic [NREQ-1:0] ack, grant, cs_n;
  logic [BITS-1:0] rd_data, spi_do;
  logic            spi_start, spi_cs;
  logic            spi_working = 1'b0;
  logic [BITS-1:0] spi_di = '0;

  logic [NREQ-1:0] ack_z, grant_z, cs_n_z;
  logic [BITS-1:0] rd_data_z, spi_do_z;
  logic            spi_start_z, spi_cs_z;
  logic            spi_working_z = 1'b0;
  logic [BITS-1:0] spi_di_z = '0;

  int m_cnt = 0;
  int m_cnt_z = 0;
  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  bit ok;

  logic [NREQ-1:0] ack_q[$];
  logic [BITS-1:0] rd_q[$];
  int start_q[$], fall_q[$], start_q_z[$], fall_q_z[$];
  int viol = 0;
  int cs_err = 0;
  int ack_long = 0;
  logic prev_w = 1'b0, prev_w_z = 1'b0;
  logic [NREQ-1:0] prev_ack = '0, prev_ack_z = '0;

  always #5 clk = ~clk;

  assign spi_cs   = ~spi_working;
  assign spi_cs_z = ~spi_working_z;

  spi_arbiter #(.NREQ(NREQ), .BITS(BITS), .IDLEGAP(5)) dut (
    .clk(clk), .rst(rst), .req(req), .reqData(req_data), .ack(ack),
    .rdData(rd_data), .grant(grant), .spiStart(spi_start),
    .spiDataOut(spi_do), .spiWorking(spi_working), .spiDataIn(spi_di),
    .spiCs(spi_cs), .csN(cs_n)
  );

  spi_arbiter #(.NREQ(NREQ), .BITS(BITS), .IDLEGAP(0)) dut_z (
    .clk(clk), .rst(rst), .req(req), .reqData(req_data), .ack(ack_z),
    .rdData(rd_data_z), .grant(grant_z), .spiStart(spi_start_z),
    .spiDataOut(spi_do_z), .spiWorking(spi_working_z), .spiDataIn(spi_di_z),
    .spiCs(spi_cs_z), .csN(cs_n_z)
  );

  // Loopback SPI masters: busy for MLEN cycles after a start, echo the word.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) spi_working <= 1'b0;
    end else if (spi_start) begin
      spi_working <= 1'b1;
      m_cnt       <= MLEN;
      spi_di      <= spi_do;
    end
    if (m_cnt_z > 0) begin
      m_cnt_z <= m_cnt_z - 1;
      if (m_cnt_z == 1) spi_working_z <= 1'b0;
    end else if (spi_start_z) begin
      spi_working_z <= 1'b1;
      m_cnt_z       <= MLEN;
      spi_di_z      <= spi_do_z;
    end
  end

  // Monitors sampled on the falling edge.
  always @(negedge clk) begin
    if (spi_start && spi_working) viol++;
    if (spi_start_z && spi_working_z) viol++;
    for (int i = 0; i < NREQ; i++) begin
      if (cs_n[i] !== (grant[i] ? spi_cs : 1'b1)) cs_err++;
      if (cs_n_z[i] !== (grant_z[i] ? spi_cs_z : 1'b1)) cs_err++;
    end
    if (ack != '0) begin
      ack_q.push_back(ack);
      rd_q.push_back(rd_data);
      if (prev_ack != '0) ack_long++;
    end
    if (ack_z != '0 && prev_ack_z != '0) ack_long++;
    prev_ack   = ack;
    prev_ack_z = ack_z;
    if (spi_start) start_q.push_back(cyc);
    if (prev_w && !spi_working) fall_q.push_back(cyc);
    prev_w = spi_working;
    if (spi_start_z) start_q_z.push_back(cyc);
    if (prev_w_z && !spi_working_z) fall_q_z.push_back(cyc);
    prev_w_z = spi_working_z;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      req = req & ~(ack & ~hold_mask);
    end
  endtask

  task automatic run_acks(input int n, input int budget, output bit done);
    int c;
    c = 0;
    done = 1'b0;
    while (!done && c < budget) begin
      tick(1);
      if (ack_q.size() >= n) done = 1'b1;
      c++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    hold_mask = '0;
    repeat (20) @(negedge clk);
    #1;
    ack_q.delete(); rd_q.delete();
    start_q.delete(); fall_q.delete(); start_q_z.delete(); fall_q_z.delete();
    viol = 0; cs_err = 0; ack_long = 0;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (grant !== 4'b0000) $display("[TB] FAIL reset_grant: got %b expected 0000", grant); else pass_cnt++;
    total_cnt++; if (ack !== 4'b0000) $display("[TB] FAIL reset_ack: got %b expected 0000", ack); else pass_cnt++;
    total_cnt++; if (rd_data !== 16'h0000) $display("[TB] FAIL reset_rdData: got %h expected 0000", rd_data); else pass_cnt++;
    total_cnt++; if (spi_do !== 16'h0000) $display("[TB] FAIL reset_spiDataOut: got %h expected 0000", spi_do); else pass_cnt++;
    total_cnt++; if (spi_start !== 1'b0) $display("[TB] FAIL reset_spiStart: got %b expected 0", spi_start); else pass_cnt++;
    total_cnt++; if (cs_n !== 4'b1111) $display("[TB] FAIL reset_csN: got %b expected 1111", cs_n); else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    req_data = {16'h4444, 16'hA55A, 16'h2222, 16'h1111};
    req = 4'b0100;
    tick(1);
    total_cnt++; if (grant !== 4'b0100) $display("[TB] FAIL single_grant: got %b expected 0100", grant); else pass_cnt++;
    total_cnt++; if (spi_start !== 1'b1) $display("[TB] FAIL single_start: got %b expected 1", spi_start); else pass_cnt++;
    total_cnt++; if (spi_do !== 16'hA55A) $display("[TB] FAIL single_dataOut: got %h expected a55a", spi_do); else pass_cnt++;
    tick(1);
    total_cnt++; if (spi_start !== 1'b0) $display("[TB] FAIL single_start_drop: got %b expected 0", spi_start); else pass_cnt++;
    total_cnt++; if (cs_n !== 4'b1011) $display("[TB] FAIL single_csN: got %b expected 1011", cs_n); else pass_cnt++;
    run_acks(1, 60, ok);
    total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL single_timeout: got %b expected 1", ok); else pass_cnt++;
    total_cnt++; if (ack_q[0] !== 4'b0100) $display("[TB] FAIL single_ack: got %b expected 0100", ack_q[0]); else pass_cnt++;
    total_cnt++; if (rd_q[0] !== 16'hA55A) $display("[TB] FAIL single_rdData: got %h expected a55a", rd_q[0]); else pass_cnt++;
    tick(30);
    total_cnt++; if (ack_q.size() !== 1) $display("[TB] FAIL single_ack_count: got %0d expected 1", ack_q.size()); else pass_cnt++;
    total_cnt++; if (rd_data !== 16'hA55A) $display("[TB] FAIL single_rdData_hold: got %h expected a55a", rd_data); else pass_cnt++;
    total_cnt++; if (cs_err !== 0) $display("[TB] FAIL single_cs_steer: got %0d errors expected 0", cs_err); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_ack [5];
    logic [BITS-1:0] exp_rd [5];
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_rd  = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h1001};
    do_reset();
    req_data = {16'h4004, 16'h3003, 16'h2002, 16'h1001};
    hold_mask = 4'b1111;
    req = 4'b1111;
    run_acks(5, 400, ok);
    req = '0;
    hold_mask = '0;
    total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL rr_timeout: got %b expected 1", ok); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      total_cnt++; if (ack_q[k] !== exp_ack[k]) $display("[TB] FAIL rr_ack%0d: got %b expected %b", k, ack_q[k], exp_ack[k]); else pass_cnt++;
      total_cnt++; if (rd_q[k] !== exp_rd[k]) $display("[TB] FAIL rr_rd%0d: got %h expected %h", k, rd_q[k], exp_rd[k]); else pass_cnt++;
    end
    tick(30);
    total_cnt++; if (ack_q.size() !== 5) $display("[TB] FAIL rr_ack_count: got %0d expected 5", ack_q.size()); else pass_cnt++;
    total_cnt++; if (viol !== 0) $display("[TB] FAIL rr_start_while_working: got %0d expected 0", viol); else pass_cnt++;
    total_cnt++; if (ack_long !== 0) $display("[TB] FAIL rr_ack_width: got %0d long acks expected 0", ack_long); else pass_cnt++;
    total_cnt++; if (cs_err !== 0) $display("[TB] FAIL rr_cs_steer: got %0d errors expected 0", cs_err); else pass_cnt++;
  endtask

  task automatic test_fairness();
    do_reset();
    req_data = {16'hD00D, 16'hC00C, 16'hB00B, 16'hA00A};
    hold_mask = 4'b0010;
    req = 4'b0010;
    tick(3);
    req = req | 4'b1000;
    run_acks(3, 300, ok);
    req = '0;
    hold_mask = '0;
    total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL fair_timeout: got %b expected 1", ok); else pass_cnt++;
    total_cnt++; if (ack_q[0] !== 4'b0010) $display("[TB] FAIL fair_first: got %b expected 0010", ack_q[0]); else pass_cnt++;
    total_cnt++; if (ack_q[1] !== 4'b1000) $display("[TB] FAIL fair_second: got %b expected 1000", ack_q[1]); else pass_cnt++;
    total_cnt++; if (ack_q[2] !== 4'b0010) $display("[TB] FAIL fair_third: got %b expected 0010", ack_q[2]); else pass_cnt++;
    total_cnt++; if (rd_q[1] !== 16'hD00D) $display("[TB] FAIL fair_rd: got %h expected d00d", rd_q[1]); else pass_cnt++;
    tick(30);
  endtask

  task automatic test_idle_gap();
    int c;
    do_reset();
    req_data = {16'h0008, 16'h0004, 16'h0002, 16'hBEEF};
    hold_mask = 4'b0001;
    req = 4'b0001;
    c = 0;
    while (start_q.size() < 2 && c < 100) begin
      tick(1);
      c++;
    end
    req = '0;
    hold_mask = '0;
    total_cnt++; if (start_q.size() < 2) $display("[TB] FAIL gap_timeout: got %0d starts expected 2", start_q.size()); else pass_cnt++;
    total_cnt++; if (start_q[1] - fall_q[0] !== 8) $display("[TB] FAIL gap5_spacing: got %0d expected 8", start_q[1] - fall_q[0]); else pass_cnt++;
    total_cnt++; if (start_q_z[1] - fall_q_z[0] !== 3) $display("[TB] FAIL gap0_spacing: got %0d expected 3", start_q_z[1] - fall_q_z[0]); else pass_cnt++;
    total_cnt++; if (rd_data_z !== 16'hBEEF) $display("[TB] FAIL gap0_rdData: got %h expected beef", rd_data_z); else pass_cnt++;
    tick(30);
    total_cnt++; if (viol !== 0) $display("[TB] FAIL gap_start_while_working: got %0d expected 0", viol); else pass_cnt++;
  endtask

  task automatic test_reset_busy();
    do_reset();
    req_data = {16'h0000, 16'h5AA5, 16'h0000, 16'h0000};
    req = 4'b0100;
    tick(4);
    rst = 1'b1;
    tick(1);
    total_cnt++; if (grant !== 4'b0000) $display("[TB] FAIL rstbusy_grant: got %b expected 0000", grant); else pass_cnt++;
    total_cnt++; if (cs_n !== 4'b1111) $display("[TB] FAIL rstbusy_csN: got %b expected 1111", cs_n); else pass_cnt++;
    total_cnt++; if (ack !== 4'b0000) $display("[TB] FAIL rstbusy_ack: got %b expected 0000", ack); else pass_cnt++;
    rst = 1'b0;
    total_cnt++; if (ack_q.size() !== 0) $display("[TB] FAIL rstbusy_no_ack: got %0d expected 0", ack_q.size()); else pass_cnt++;
    run_acks(1, 100, ok);
    total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL rstbusy_timeout: got %b expected 1", ok); else pass_cnt++;
    total_cnt++; if (ack_q[0] !== 4'b0100) $display("[TB] FAIL rstbusy_ack_later: got %b expected 0100", ack_q[0]); else pass_cnt++;
    total_cnt++; if (rd_q[0] !== 16'h5AA5) $display("[TB] FAIL rstbusy_rd: got %h expected 5aa5", rd_q[0]); else pass_cnt++;
    tick(30);
    total_cnt++; if (viol !== 0) $display("[TB] FAIL rstbusy_start_while_working: got %0d expected 0", viol); else pass_cnt++;
  endtask

  task automatic test_drop_in_busy();
    do_reset();
    req_data = {16'h0000, 16'h0000, 16'h0000, 16'h0F0F};
    req = 4'b0001;
    tick(3);
    req = 4'b0000;
    run_acks(1, 100, ok);
    total_cnt++; if (ok !== 1'b1) $display("[TB] FAIL drop_timeout: got %b expected 1", ok); else pass_cnt++;
    total_cnt++; if (ack_q[0] !== 4'b0001) $display("[TB] FAIL drop_ack: got %b expected 0001", ack_q[0]); else pass_cnt++;
    total_cnt++; if (rd_q[0] !== 16'h0F0F) $display("[TB] FAIL drop_rd: got %h expected 0f0f", rd_q[0]); else pass_cnt++;
    tick(40);
    total_cnt++; if (ack_q.size() !== 1) $display("[TB] FAIL drop_ack_count: got %0d expected 1", ack_q.size()); else pass_cnt++;
    total_cnt++; if (start_q.size() !== 1) $display("[TB] FAIL drop_start_count: got %0d expected 1", start_q.size()); else pass_cnt++;
  endtask

  initial begin
    $display("[TB] spi_arbiter directed tests");
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_idle_gap();
    test_reset_busy();
    test_drop_in_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
